cell_row_fetch: RTL and testbench

- Read-side consumer of the cell RAM that the evolution engine writes.
- On a per-scanline request, streams one grid row out of RAM (block by block, READ_COL blocks at a time) into a ping-pong line buffer.
- Answers per-pixel-column liveness queries from the display timing logic while the next row is fetched.
- Sits between the cell RAM read port and the VGA pixel generator.

---
 rtl/cell_row_fetch_pkg.sv | 27 ++
 rtl/cell_row_fetch_line_buf_pp.sv | 66 ++++++
 rtl/cell_row_fetch.sv | 114 +++++++++++
 tb/tb_cell_row_fetch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cell_row_fetch_pkg.sv
// Shared definitions for the cell row fetcher: grid geometry, FSM encoding
// and the RAM word address helper.
package cell_row_fetch_pkg;

  localparam int P_PARAM_M = 5;            // grid rows
  localparam int P_PARAM_N = 5;            // grid columns (cells)
  localparam int WIDTH     = 12;           // coordinate width
  localparam int BLOCK_LEN = 1;            // cells per RAM word
  localparam int READ_COL  = 5;            // RAM words per grid row
  localparam int ADDR_W    = 2 * WIDTH;    // RAM word address width
  localparam int COL_W     = (P_PARAM_N > 1) ? $clog2(P_PARAM_N) : 1;

  // Fetch FSM encoding, kept as plain constants for compatibility with
  // existing logic that compares raw state codes.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_ZERO  = 3'd3;
  localparam logic [2:0] ST_SWAP  = 3'd4;

  // Word address of block k within a grid row.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [WIDTH-1:0] row,
                                                input logic [WIDTH-1:0] k);
    return ({{WIDTH{1'b0}}, row} * ADDR_W'(READ_COL)) + {{WIDTH{1'b0}}, k};
  endfunction

endpackage

// File: rtl/cell_row_fetch_line_buf_pp.sv
// Ping-pong line buffer: one half is filled block by block while the other
// half answers single-cell liveness queries with one cycle of latency.
module line_buf_pp
  import cell_row_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fill_we,
  input  logic [WIDTH-1:0]     fill_idx,
  input  logic [BLOCK_LEN-1:0] fill_data,
  input  logic                 fill_clr,
  input  logic                 swap,
  input  logic [WIDTH-1:0]     rd_col,
  output logic                 rd_bit
);

  logic [P_PARAM_N-1:0] buf_q [2];
  logic                 sel_q;      // index of the display half
  logic [P_PARAM_N-1:0] fill_cur;
  logic [P_PARAM_N-1:0] fill_nxt;
  logic [P_PARAM_N-1:0] disp_cur;

  assign fill_cur = buf_q[!sel_q];
  assign disp_cur = buf_q[sel_q];

  // Next value of the fill half: clear, or merge one RAM word at its block slot.
  always_comb begin
    // NOTE: default assignment first so no path leaves fill_nxt unassigned (no latch).
    fill_nxt = fill_cur;
    if (fill_clr) begin
      fill_nxt = '0;
    end else if (fill_we) begin
      for (int b = 0; b < READ_COL; b++) begin
        if (fill_idx == WIDTH'(b)) begin
          for (int j = 0; j < BLOCK_LEN; j++) begin
            fill_nxt[b*BLOCK_LEN + j] = fill_data[j];
          end
        end
      end
    end
  end

  // Buffer halves and display select; only the fill half is ever written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: these are tiny flop arrays, so both halves are reset; a reset
      // must leave the display reading all-dead cells.
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      sel_q    <= 1'b0;
    end else begin
      buf_q[!sel_q] <= fill_nxt;
      if (swap) sel_q <= !sel_q;
    end
  end

  // Registered query; columns beyond the grid read as dead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_bit <= 1'b0;
    end else begin
      rd_bit <= (rd_col < WIDTH'(P_PARAM_N)) ? disp_cur[rd_col[COL_W-1:0]] : 1'b0;
    end
  end

endmodule

// File: rtl/cell_row_fetch.sv
// Cell row fetcher: on a scanline request, streams one grid row from the
// cell RAM into a ping-pong line buffer and swaps it to display when full.
// Optional macro FETCH_OVERRUN_EN: a request during a fetch restarts it and
// sets the sticky fetch_overrun flag; otherwise such requests are ignored.
module cell_row_fetch
  import cell_row_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 line_req,
  input  logic [WIDTH-1:0]     line_row,
  input  logic                 rd_grant,
  output logic [2*WIDTH-1:0]   rd_pos,
  output logic                 rd_en,
  input  logic [BLOCK_LEN-1:0] rd_val,
  output logic                 line_busy,
  output logic                 line_ready,
  input  logic [WIDTH-1:0]     pix_col,
  output logic                 pix_live
`ifdef FETCH_OVERRUN_EN
  ,
  output logic                 fetch_overrun
`endif
);

  logic [2:0]        state_q;
  logic [ADDR_W-1:0] base_q;      // row * READ_COL, fixed for the whole fetch
  logic [WIDTH-1:0]  k_q;         // next block to read
  logic              cap_vld_q;   // rd_val carries the word read last cycle
  logic [WIDTH-1:0]  cap_k_q;     // block index of that word
  logic              busy;
  logic              start;
  logic              restart;
  logic              last_issue;

  assign busy = (state_q != ST_IDLE);

`ifdef FETCH_OVERRUN_EN
  assign restart = line_req && busy;
  assign start   = line_req;
`else
  assign restart = 1'b0;
  assign start   = line_req && !busy;
`endif

  assign rd_en      = (state_q == ST_ISSUE) && rd_grant && !restart;
  assign rd_pos     = (state_q == ST_ISSUE) ? base_q + {{WIDTH{1'b0}}, k_q} : '0;
  assign last_issue = rd_en && (k_q == WIDTH'(READ_COL - 1));
  assign line_busy  = busy;
  assign line_ready = (state_q == ST_SWAP) && !restart;

  // Fetch sequencing: latch the row, issue READ_COL reads around stalls, drain, swap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      k_q     <= '0;
    end else if (start) begin
      // NOTE: non-blocking everywhere in sequential logic, so every branch
      // sees the pre-edge values of state_q and k_q.
      base_q  <= addr_of(line_row, '0);
      k_q     <= '0;
      state_q <= (line_row < WIDTH'(P_PARAM_M)) ? ST_ISSUE : ST_ZERO;
    end else begin
      case (state_q)
        ST_ISSUE: begin
          if (rd_en) begin
            k_q <= k_q + 1'b1;
            if (last_issue) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: state_q <= ST_SWAP;
        ST_ZERO:  state_q <= ST_SWAP;
        ST_SWAP:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Capture tracking: the RAM answers one cycle after each issued read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_vld_q <= 1'b0;
      cap_k_q   <= '0;
    end else begin
      cap_vld_q <= rd_en;
      cap_k_q   <= k_q;
    end
  end

`ifdef FETCH_OVERRUN_EN
  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_overrun <= 1'b0;
    end else if (restart) begin
      fetch_overrun <= 1'b1;
    end
  end
`endif

  line_buf_pp u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .fill_we   (cap_vld_q),
    .fill_idx  (cap_k_q),
    .fill_data (rd_val),
    .fill_clr  (state_q == ST_ZERO),
    .swap      (line_ready),
    .rd_col    (pix_col),
    .rd_bit    (pix_live)
  );

endmodule

// File: tb/tb_cell_row_fetch.sv
// Self-checking bench for cell_row_fetch: directed scenarios plus randomized
// fetches, compared against a transaction-level model of the row fetch.
module tb_cell_row_fetch;
  import cell_row_fetch_pkg::*;

  localparam int NW = P_PARAM_M * READ_COL;
`ifdef FETCH_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 line_req;
  logic [WIDTH-1:0]     line_row;
  logic                 rd_grant;
  logic [2*WIDTH-1:0]   rd_pos;
  logic                 rd_en;
  logic [BLOCK_LEN-1:0] rd_val;
  logic                 line_busy;
  logic                 line_ready;
  logic [WIDTH-1:0]     pix_col;
  logic                 pix_live;
`ifdef FETCH_OVERRUN_EN
  logic                 fetch_overrun;
`endif

  cell_row_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .line_req   (line_req),
    .line_row   (line_row),
    .rd_grant   (rd_grant),
    .rd_pos     (rd_pos),
    .rd_en      (rd_en),
    .rd_val     (rd_val),
    .line_busy  (line_busy),
    .line_ready (line_ready),
    .pix_col    (pix_col),
    .pix_live   (pix_live)
`ifdef FETCH_OVERRUN_EN
    ,
    .fetch_overrun (fetch_overrun)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Environment: cell RAM contents and its one-cycle read response.
  logic [BLOCK_LEN-1:0] ram [NW];
  bit                   pend;
  logic [ADDR_W-1:0]    pend_addr;

  // Reference model state (fetch-level view).
  bit                 act;        // a fetch has been accepted and not delivered
  int                 start_c;    // cycle the request was accepted
  int                 ready_c;    // cycle line_ready is due (-1: not yet known)
  int                 k_exp;      // reads delivered so far
  int                 f_row;
  bit [P_PARAM_N-1:0] disp_m;     // what the display buffer should hold
  bit                 exp_live;   // pix_live due at the next sample
  bit                 overrun_m;
  int                 cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit row_bit(input int r, input int c);
    if (r >= P_PARAM_M || c >= P_PARAM_N) return 1'b0;
    return ram[r*READ_COL + c/BLOCK_LEN][c%BLOCK_LEN];
  endfunction

  // One clock cycle: drive inputs (entered at posedge+1), sample at negedge.
  task automatic cycle_step(input bit req, input int row, input bit grant, input int col);
    bit busy_e, restart, en_e, ready_e;
    line_req = req;
    line_row = WIDTH'(row);
    rd_grant = grant;
    pix_col  = WIDTH'(col);
    @(negedge clk);
    rd_val    = (pend && pend_addr < NW) ? ram[pend_addr] : '0;
    pend      = rd_en;
    pend_addr = rd_pos;

    busy_e  = act && (cyc > start_c);
    restart = OVR && req && busy_e;
    en_e    = busy_e && (f_row < P_PARAM_M) && (k_exp < READ_COL) && grant && !restart;
    check("rd_en", rd_en, en_e);
    if (en_e) begin
      check("rd_pos", rd_pos, f_row*READ_COL + k_exp);
      k_exp++;
      if (k_exp == READ_COL) ready_c = cyc + 2;
    end
    ready_e = busy_e && (cyc == ready_c) && !restart;
    check("line_ready", line_ready, ready_e);
    check("line_busy", line_busy, busy_e);
    check("pix_live", pix_live, exp_live);
`ifdef FETCH_OVERRUN_EN
    check("fetch_overrun", fetch_overrun, overrun_m);
`endif
    exp_live = (col < P_PARAM_N) ? disp_m[col] : 1'b0;
    if (ready_e) begin
      for (int c = 0; c < P_PARAM_N; c++) disp_m[c] = row_bit(f_row, c);
      act = 1'b0;
    end
    if (req && (!busy_e || OVR)) begin
      if (busy_e) overrun_m = 1'b1;
      act     = 1'b1;
      start_c = cyc;
      f_row   = row;
      k_exp   = 0;
      ready_c = (row >= P_PARAM_M) ? cyc + 2 : -1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // gmode: 0 grant always, 1 grant low on cycles 3..5, 2 random.
  // cmode: 0 sweep 0..5, 1 hold column 2, 2 random 0..7.
  task automatic run_fetch(input int row, input int ncyc, input int gmode, input int cmode,
                           input int ovl_at, input int ovl_row);
    for (int i = 0; i < ncyc; i++) begin
      bit req, g;
      int r, c;
      req = (i == 0) || (i == ovl_at);
      r   = (i == ovl_at) ? ovl_row : row;
      case (gmode)
        0:       g = 1'b1;
        1:       g = !(i >= 3 && i <= 5);
        default: g = ($urandom_range(0, 9) < 7);
      endcase
      case (cmode)
        0:       c = i % 6;
        1:       c = 2;
        default: c = $urandom_range(0, 7);
      endcase
      cycle_step(req, r, g, c);
    end
  endtask

  task automatic query_sweep();
    for (int c = 0; c < 7; c++) cycle_step(1'b0, 0, 1'b1, (c == 5) ? 9 : c);
    cycle_step(1'b0, 0, 1'b0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, rd_en, 1'b0);
    check({tag, "_rd_pos"}, rd_pos, 0);
    check({tag, "_busy"}, line_busy, 1'b0);
    check({tag, "_ready"}, line_ready, 1'b0);
    check({tag, "_pix_live"}, pix_live, 1'b0);
`ifdef FETCH_OVERRUN_EN
    check({tag, "_overrun"}, fetch_overrun, 1'b0);
`endif
  endtask

  task automatic model_reset();
    act = 1'b0; start_c = 0; ready_c = -1; k_exp = 0; f_row = 0;
    disp_m = '0; exp_live = 1'b0; overrun_m = 1'b0; pend = 1'b0; pend_addr = '0;
  endtask

  initial begin
    // NOTE: bench inputs are driven with blocking assignments one time unit
    // after the clock edge, so the DUT never races its own sampling edge.
    rst = 1'b0; line_req = 1'b0; line_row = '0; rd_grant = 1'b0; pix_col = '0; rd_val = '0;
    for (int a = 0; a < NW; a++) ram[a] = BLOCK_LEN'($urandom);
    ram[10] = 1; ram[11] = 0; ram[12] = 1; ram[13] = 1; ram[14] = 0;
    model_reset();
    cyc = 0;

    #3;
    check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Row 2, no stalls: addresses 10..14, ready 7 cycles after the request.
    run_fetch(2, 12, 0, 0, -1, 0);
    query_sweep();
    // Same row with a three-cycle grant stall after the second read.
    run_fetch(2, 14, 1, 0, -1, 0);
    query_sweep();
    // Out-of-range row: no reads, ready after 2 cycles, all cells dead.
    run_fetch(7, 6, 0, 2, -1, 0);
    query_sweep();
    // Overlapping request on cycle 3 of a fetch.
    run_fetch(1, 14, 0, 2, 3, 3);
    query_sweep();

    // Reset in the middle of ISSUE aborts at once.
    run_fetch(4, 3, 0, 0, -1, 0);
    line_req = 1'b0; rd_grant = 1'b1;
    rst = 1'b0;
    #2;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    query_sweep();
    run_fetch(3, 12, 2, 2, -1, 0);
    query_sweep();

    // Column 2 held across a swap from an all-dead row to row 2.
    run_fetch(7, 5, 0, 1, -1, 0);
    run_fetch(2, 12, 0, 1, -1, 0);

    // Randomized fetches with random stalls, queries and occasional overlaps.
    repeat (20) begin
      int row, ovl;
      row = $urandom_range(0, 6);
      ovl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : -1;
      run_fetch(row, 24, 2, 2, ovl, $urandom_range(0, 6));
    end
    query_sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
